// File: rtl/fifo_pkg.sv
// Shared types and default sizing for the FIFO push-side arbiter.
package fifo_pkg;

  localparam int DATA_WIDTH = 8;
  localparam int N_REQ      = 4;
  localparam int MAX_BURST  = 4;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    STALL = 2'd2
  } arb_state_t;

  typedef logic [$clog2(N_REQ)-1:0] req_id_t;

endpackage

// File: rtl/fifo_push_arbiter_picker.sv
// Round-robin pick: first requester after last_grant, wrapping, so the last winner is checked last.
module rr_priority_picker #(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic                     valid,
  output logic [$clog2(N_REQ)-1:0] pick
);
  import fifo_pkg::*;

  localparam int IDW = $clog2(N_REQ);

  always_comb begin
    valid = FALSE;
    pick  = '0;
    for (int k = 1; k <= N_REQ; k++) begin
      if (!valid && req[(int'(last_grant) + k) % N_REQ]) begin
        valid = TRUE;
        pick  = IDW'((int'(last_grant) + k) % N_REQ);
      end
    end
  end

endmodule

// File: rtl/fifo_push_arbiter.sv
// Shares the FIFO push port among N_REQ producers with round-robin bursts, gated by full.
//  state | meaning
//  IDLE  | no grant held, arbitrating on any req
//  BURST | grant_id owns the push port, pushes while req and not full
//  STALL | grant_id holds the port but FIFO is full, waiting for space
module fifo_push_arbiter #(
  parameter int N_REQ      = fifo_pkg::N_REQ,
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH,
  parameter int MAX_BURST  = fifo_pkg::MAX_BURST
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [N_REQ-1:0]                     req,
  input  logic [N_REQ-1:0][DATA_WIDTH-1:0]     data_in,
  input  logic                                 full,
  output logic                                 push,
  output logic [DATA_WIDTH-1:0]                push_data,
  output logic [N_REQ-1:0]                     ack,
  output logic [$clog2(N_REQ)-1:0]             grant_id,
  output logic                                 busy
);
  import fifo_pkg::*;

  localparam int IDW   = $clog2(N_REQ);
  localparam int CNT_W = $clog2(MAX_BURST) + 1;

  arb_state_t       state;
  logic [IDW-1:0]   last_grant;
  logic [CNT_W-1:0] burst_cnt;

  logic             granted_req;
  logic [N_REQ-1:0] grant_oh;
  logic [N_REQ-1:0] cand;
  logic [IDW-1:0]   scan_from;
  logic             pick_valid;
  logic [IDW-1:0]   pick;
  logic             burst_last;
  logic             rel;

  assign granted_req = req[grant_id];
  assign grant_oh    = N_REQ'(1) << grant_id;
  assign burst_last  = (burst_cnt == CNT_W'(MAX_BURST - 1));

  // On release the current grantee becomes last_grant, so scan from it in the same cycle.
  assign scan_from = (state == IDLE) ? last_grant : grant_id;
  assign cand      = (state != IDLE && !granted_req) ? (req & ~grant_oh) : req;

  assign rel = ((state == BURST) && (!granted_req || (!full && burst_last)))
            || ((state == STALL) && !granted_req);

  assign push      = (state == BURST) && granted_req && !full;
  assign ack       = push ? grant_oh : '0;
  assign push_data = data_in[grant_id];
  assign busy      = (state == BURST) || (state == STALL);

  rr_priority_picker #(.N_REQ(N_REQ)) u_picker (
    .req        (cand),
    .last_grant (scan_from),
    .valid      (pick_valid),
    .pick       (pick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant_id   <= '0;
      last_grant <= IDW'(N_REQ - 1);
      burst_cnt  <= '0;
    end else if (rel) begin
      last_grant <= grant_id;
      burst_cnt  <= '0;
      if (pick_valid) begin
        grant_id <= pick;
        state    <= BURST;
      end else begin
        state <= IDLE;
      end
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant_id  <= pick;
            burst_cnt <= '0;
            state     <= BURST;
          end
        end
        BURST: begin
          if (full) state <= STALL;
          else      burst_cnt <= burst_cnt + CNT_W'(1);
        end
        STALL: begin
          if (!full) state <= BURST;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Table-driven check of the push arbiter plus a persistent-producer burst sequence.
module tb_fifo_push_arbiter;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [3:0]       req = 4'b0000;
  logic [3:0][7:0]  data_in;
  logic             full = 1'b0;
  logic             push;
  logic [7:0]       push_data;
  logic [3:0]       ack;
  logic [1:0]       grant_id;
  logic             busy;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic [3:0] req;
    logic       full;
    logic       push;
    logic [3:0] ack;
    logic [1:0] gid;
    logic       busy;
  } vec_t;

  vec_t       vecs[$];
  vec_t       exp_q[$];
  logic [7:0] data_q[$];

  fifo_push_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data_in   (data_in),
    .full      (full),
    .push      (push),
    .push_data (push_data),
    .ack       (ack),
    .grant_id  (grant_id),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp_v);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] rq, input logic f, input logic p,
                     input logic [3:0] a, input logic [1:0] g, input logic b, input int n = 1);
    vec_t v;
    v.rst = r; v.req = rq; v.full = f; v.push = p; v.ack = a; v.gid = g; v.busy = b;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endtask

  initial begin
    vec_t       e;
    int         pushes;
    int         last_cyc;
    logic       adv;
    logic [7:0] wexp;

    data_in[0] = 8'h11; data_in[1] = 8'hA5; data_in[2] = 8'h5A; data_in[3] = 8'h3C;

    // reset held with all requesting, then release and round-robin bursts of four
    add(0, 4'b1111, 0, 0, 4'b0000, 0, 0, 2);
    add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 1, 4'b0001, 0, 1, 4);
    add(1, 4'b1111, 0, 1, 4'b0010, 1, 1, 4);
    add(1, 4'b1111, 0, 1, 4'b0100, 2, 1, 4);
    add(1, 4'b1111, 0, 1, 4'b1000, 3, 1, 4);
    add(1, 4'b1111, 0, 1, 4'b0001, 0, 1);
    add(0, 4'b1111, 0, 0, 4'b0000, 0, 0);
    // single producer 1, three pushes, then withdraw to idle
    add(1, 4'b0010, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b0010, 0, 1, 4'b0010, 1, 1, 3);
    add(1, 4'b0000, 0, 0, 4'b0000, 1, 1);
    add(1, 4'b0000, 0, 0, 4'b0000, 1, 0);
    // producer 2: two pushes, full for three cycles, resume, finish, hand over to 3
    add(1, 4'b1100, 0, 0, 4'b0000, 1, 0);
    add(1, 4'b1100, 0, 1, 4'b0100, 2, 1, 2);
    add(1, 4'b1100, 1, 0, 4'b0000, 2, 1, 3);
    add(1, 4'b1100, 0, 0, 4'b0000, 2, 1);
    add(1, 4'b1100, 0, 1, 4'b0100, 2, 1, 2);
    add(1, 4'b1100, 0, 1, 4'b1000, 3, 1);
    // producer 3 withdraws after one push, producer 0 taken with no bubble
    add(1, 4'b0001, 0, 0, 4'b0000, 3, 1);
    add(1, 4'b0001, 0, 1, 4'b0001, 0, 1);
    add(1, 4'b0010, 0, 0, 4'b0000, 0, 1);
    add(1, 4'b0010, 0, 1, 4'b0010, 1, 1, 2);
    // async reset mid-burst (grant 1, two pushes done), restart at producer 0
    add(0, 4'b0010, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 0, 4'b0000, 0, 0);
    add(1, 4'b1111, 0, 1, 4'b0001, 0, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      rst  = vecs[k].rst;
      req  = vecs[k].req;
      full = vecs[k].full;
      exp_q.push_back(vecs[k]);
      #1;
      e = exp_q.pop_front();
      check($sformatf("v%0d.push", k), 32'(push), 32'(e.push));
      check($sformatf("v%0d.ack", k), 32'(ack), 32'(e.ack));
      check($sformatf("v%0d.grant_id", k), 32'(grant_id), 32'(e.gid));
      check($sformatf("v%0d.busy", k), 32'(busy), 32'(e.busy));
      check($sformatf("v%0d.push_data", k), 32'(push_data), 32'(data_in[e.gid]));
    end

    // persistent producer 2 advancing its word after each ack: ten pushes back to back
    @(negedge clk);
    rst = 1'b0; req = 4'b0000;
    @(negedge clk);
    rst = 1'b1; req = 4'b0100; data_in[2] = 8'h40;
    data_q.push_back(8'h40);
    #1;
    check("persist.arb_latency", 32'(push), 32'(0));
    pushes = 0; last_cyc = -1; adv = 1'b0;
    for (int cyc = 1; cyc < 20; cyc++) begin
      @(negedge clk);
      if (adv) begin
        data_in[2] = data_in[2] + 8'h01;
        data_q.push_back(data_in[2]);
        adv = 1'b0;
      end
      #1;
      if (push) begin
        wexp = (data_q.size() > 0) ? data_q.pop_front() : 8'hXX;
        check($sformatf("persist.data%0d", pushes), 32'(push_data), 32'(wexp));
        check($sformatf("persist.ack%0d", pushes), 32'(ack), 32'(4'b0100));
        adv = 1'b1;
        pushes++;
        if (pushes == 10) begin
          last_cyc = cyc;
          break;
        end
      end
    end
    check("persist.no_lost_cycle", 32'(last_cyc), 32'(10));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
